spike_residue_array: RTL and testbench

- Multi-channel, clocked successor to the CSP spike/residue stage.
- Holds one membrane potential per output neuron and accumulates partial-sum beats for one timestep.
- At the end of the timestep it thresholds every channel in parallel and emits a spike vector plus a residue vector over a valid/ready handshake.
- Sits between the PE partial-sum adder tree and the spike output router.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/spike_residue_lane.sv | 67 ++++++
 rtl/spike_residue_array.sv | 89 ++++++++
 tb/tb_spike_residue_array.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath blocks.
package snn_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FIRE  = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam int RESET_SUBTRACT = 0;
   localparam int RESET_ZERO     = 1;

   // Unsigned add clamped to 2^w-1. Operands are zero-extended to 32 bits;
   // the extra sum bit stands in for the WIDTH+1 adder carry.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/spike_residue_lane.sv
// One neuron channel: membrane register with saturating accumulate, clear,
// and threshold/post-spike reset. Registers its own spike/residue result.
// Optional leak of non-spiking membranes: SPIKE_RESIDUE_LEAK_EN.
module spike_residue_lane
   import snn_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int THRESHOLD  = 64,
`ifdef SPIKE_RESIDUE_LEAK_EN
   parameter int LEAK_SHIFT = 3,
`endif
   parameter int RESET_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc,
   input  logic             clr,
   input  logic             fire,
   input  logic [WIDTH-1:0] din,
   output logic             spike,
   output logic [WIDTH-1:0] residue
);

   localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

   logic [WIDTH-1:0] mem_q, mem_d, base, res_d;
   logic             spike_d;

   // Next membrane: fire has priority (acc/clr are never set outside ACCUM);
   // a clear zeroes the base before a same-cycle beat is added.
   always_comb begin
      base    = clr ? '0 : mem_q;
      mem_d   = mem_q;
      spike_d = spike;
      res_d   = residue;
      if (fire) begin
         if (mem_q > THR) begin
            spike_d = 1'b1;
            mem_d   = (RESET_MODE == RESET_ZERO) ? '0 : mem_q - THR;
         end else begin
            spike_d = 1'b0;
`ifdef SPIKE_RESIDUE_LEAK_EN
            mem_d   = mem_q - (mem_q >> LEAK_SHIFT);
`endif
         end
         res_d = mem_d;
      end else if (acc) begin
         mem_d = WIDTH'(sat_add(32'(base), 32'(din), WIDTH));
      end else if (clr) begin
         mem_d = '0;
      end
   end

   // Membrane and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '0;
         spike   <= 1'b0;
         residue <= '0;
      end else begin
         mem_q   <= mem_d;
         spike   <= spike_d;
         residue <= res_d;
      end
   end

endmodule

// File: rtl/spike_residue_array.sv
// Multi-channel spike/residue stage: accumulates partial-sum beats for one
// timestep, then thresholds all channels at once and hands the spike and
// residue vectors downstream over valid/ready.
// Optional leak of non-spiking membranes: SPIKE_RESIDUE_LEAK_EN.
//
// state | meaning
// ACCUM | accepting beats; clear honoured here only
// FIRE  | one cycle: threshold every lane, register results
// OUT   | result valid, held until out_ready
module spike_residue_array
   import snn_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int WIDTH      = 8,
   parameter int THRESHOLD  = 64,
   parameter int RESET_MODE = 0,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic                    in_last,
   input  logic                    clear,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH-1:0]       out_spike,
   output logic [NUM_CH*WIDTH-1:0] out_residue
);

   if (LEAK_SHIFT < 0 || LEAK_SHIFT >= WIDTH) begin : g_bad_leak_shift
      $error("LEAK_SHIFT must lie in [0, WIDTH-1]");
   end

   state_t state_q, state_d;
   logic   acc, clr, fire;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   // Next state and handshake outputs; out_valid is decoded from state so an
   // async reset drops it immediately.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_d = FIRE;
         end
         FIRE:  state_d = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   assign acc  = in_valid & in_ready;
   assign clr  = clear & in_ready;
   assign fire = (state_q == FIRE);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      spike_residue_lane #(
         .WIDTH      (WIDTH),
         .THRESHOLD  (THRESHOLD),
`ifdef SPIKE_RESIDUE_LEAK_EN
         .LEAK_SHIFT (LEAK_SHIFT),
`endif
         .RESET_MODE (RESET_MODE)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .acc     (acc),
         .clr     (clr),
         .fire    (fire),
         .din     (in_data[c*WIDTH +: WIDTH]),
         .spike   (out_spike[c]),
         .residue (out_residue[c*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_spike_residue_array.sv
// Directed bench for spike_residue_array. Two instances share stimulus:
// dut0 subtracts THRESHOLD after a spike, dut1 resets to zero.
module tb_spike_residue_array;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_last, clear, out_ready;
   logic [31:0] in_data;
   logic        in_ready0, out_valid0, in_ready1, out_valid1;
   logic [3:0]  spike0, spike1;
   logic [31:0] res0, res1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spike_residue_array #(.NUM_CH(4), .WIDTH(8), .THRESHOLD(64), .RESET_MODE(0), .LEAK_SHIFT(3)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .in_last(in_last), .clear(clear), .out_valid(out_valid0), .out_ready(out_ready),
      .out_spike(spike0), .out_residue(res0));

   spike_residue_array #(.NUM_CH(4), .WIDTH(8), .THRESHOLD(64), .RESET_MODE(1), .LEAK_SHIFT(3)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .in_last(in_last), .clear(clear), .out_valid(out_valid1), .out_ready(out_ready),
      .out_spike(spike1), .out_residue(res1));

   function automatic logic [31:0] pk(input logic [7:0] c3, input logic [7:0] c2,
                                      input logic [7:0] c1, input logic [7:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic send_beat(input logic [31:0] d, input logic last, input logic clr);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = last; clear = clr;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int k = 0;
      while (!out_valid0 && k < 10) begin
         @(posedge clk); #1; k++;
      end
      n_cmp++;
      if (out_valid0 !== 1'b1) begin
         n_err++; $display("FAIL %s_timeout out_valid=%b expected 1", name, out_valid0);
      end
   endtask

   task automatic consume(input string name);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      n_cmp++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
         n_err++; $display("FAIL %s_consume out_valid=%b in_ready=%b expected 0 1", name, out_valid0, in_ready0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; in_last = 0; clear = 0; out_ready = 0; in_data = '0;
      #12;
      n_cmp++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || spike0 !== 4'b0 || res0 !== 32'h0) begin
         n_err++; $display("FAIL reset ov=%b ir=%b sp=%b res=%h expected 0 1 0 0", out_valid0, in_ready0, spike0, res0);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single_fire();
      send_beat(pk(0, 0, 0, 100), 1'b1, 1'b1);
      n_cmp++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
         n_err++; $display("FAIL single_fire_state in_ready=%b out_valid=%b expected 0 0", in_ready0, out_valid0);
      end
      wait_out("single");
      n_cmp++;
      if (spike0 !== 4'b0001 || res0 !== pk(0, 0, 0, 36)) begin
         n_err++; $display("FAIL single_dut0 spike=%b res=%h expected 0001 %h", spike0, res0, pk(0, 0, 0, 36));
      end
      n_cmp++;
      if (spike1 !== 4'b0001 || res1 !== 32'h0) begin
         n_err++; $display("FAIL single_dut1 spike=%b res=%h expected 0001 0", spike1, res1);
      end
      consume("single");
   endtask

   task automatic test_threshold();
      send_beat(pk(0, 0, 65, 64), 1'b1, 1'b1);
      wait_out("thr_a");
      n_cmp++;
      if (spike0 !== 4'b0010 || res0 !== pk(0, 0, 1, 64)) begin
         n_err++; $display("FAIL thr_a_dut0 spike=%b res=%h expected 0010 %h", spike0, res0, pk(0, 0, 1, 64));
      end
      n_cmp++;
      if (spike1 !== 4'b0010 || res1 !== pk(0, 0, 0, 64)) begin
         n_err++; $display("FAIL thr_a_dut1 spike=%b res=%h expected 0010 %h", spike1, res1, pk(0, 0, 0, 64));
      end
      consume("thr_a");
      send_beat(pk(0, 0, 0, 1), 1'b1, 1'b0);
      wait_out("thr_b");
      n_cmp++;
      if (spike0 !== 4'b0001 || res0 !== pk(0, 0, 1, 1)) begin
         n_err++; $display("FAIL thr_b_dut0 spike=%b res=%h expected 0001 %h", spike0, res0, pk(0, 0, 1, 1));
      end
      n_cmp++;
      if (spike1 !== 4'b0001 || res1 !== 32'h0) begin
         n_err++; $display("FAIL thr_b_dut1 spike=%b res=%h expected 0001 0", spike1, res1);
      end
      consume("thr_b");
   endtask

   task automatic test_saturation();
      send_beat(pk(255, 0, 0, 200), 1'b0, 1'b1);
      n_cmp++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
         n_err++; $display("FAIL sat_midstep in_ready=%b out_valid=%b expected 1 0", in_ready0, out_valid0);
      end
      send_beat(pk(1, 0, 0, 100), 1'b1, 1'b0);
      wait_out("sat");
      n_cmp++;
      if (spike0 !== 4'b1001 || res0 !== pk(191, 0, 0, 191)) begin
         n_err++; $display("FAIL sat_dut0 spike=%b res=%h expected 1001 %h", spike0, res0, pk(191, 0, 0, 191));
      end
      n_cmp++;
      if (spike1 !== 4'b1001 || res1 !== 32'h0) begin
         n_err++; $display("FAIL sat_dut1 spike=%b res=%h expected 1001 0", spike1, res1);
      end
      consume("sat");
   endtask

   task automatic test_backpressure();
      send_beat(pk(0, 0, 0, 80), 1'b1, 1'b1);
      wait_out("bp");
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(9, 9, 9, 50); in_last = 1'b1; clear = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || spike0 !== 4'b0001 || res0 !== pk(0, 0, 0, 16)) begin
            n_err++; $display("FAIL bp_hold%0d ov=%b ir=%b sp=%b res=%h expected 1 0 0001 %h",
                              i, out_valid0, in_ready0, spike0, res0, pk(0, 0, 0, 16));
         end
      end
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0;
      consume("bp");
      send_beat(pk(0, 0, 0, 0), 1'b1, 1'b0);
      wait_out("bp_after");
      n_cmp++;
      if (spike0 !== 4'b0000 || res0 !== pk(0, 0, 0, 16)) begin
         n_err++; $display("FAIL bp_ignored_dut0 spike=%b res=%h expected 0000 %h", spike0, res0, pk(0, 0, 0, 16));
      end
      n_cmp++;
      if (spike1 !== 4'b0000 || res1 !== 32'h0) begin
         n_err++; $display("FAIL bp_ignored_dut1 spike=%b res=%h expected 0000 0", spike1, res1);
      end
      consume("bp_after");
   endtask

   task automatic test_clear();
      send_beat(pk(0, 0, 0, 50), 1'b1, 1'b1);
      wait_out("clr_a");
      n_cmp++;
      if (spike0 !== 4'b0000 || res0 !== pk(0, 0, 0, 50)) begin
         n_err++; $display("FAIL clr_carry spike=%b res=%h expected 0000 %h", spike0, res0, pk(0, 0, 0, 50));
      end
      consume("clr_a");
      send_beat(pk(0, 0, 0, 20), 1'b1, 1'b1);
      wait_out("clr_b");
      n_cmp++;
      if (spike0 !== 4'b0000 || res0 !== pk(0, 0, 0, 20)) begin
         n_err++; $display("FAIL clr_with_beat spike=%b res=%h expected 0000 %h", spike0, res0, pk(0, 0, 0, 20));
      end
      consume("clr_b");
      send_beat(pk(0, 7, 0, 5), 1'b0, 1'b0);
      @(negedge clk); clear = 1'b1;
      @(posedge clk); #1; clear = 1'b0;
      send_beat(pk(0, 0, 0, 3), 1'b1, 1'b0);
      wait_out("clr_c");
      n_cmp++;
      if (spike0 !== 4'b0000 || res0 !== pk(0, 0, 0, 3)) begin
         n_err++; $display("FAIL clr_alone spike=%b res=%h expected 0000 %h", spike0, res0, pk(0, 0, 0, 3));
      end
      consume("clr_c");
   endtask

   task automatic test_async_reset();
      send_beat(pk(10, 10, 10, 100), 1'b1, 1'b0);
      wait_out("ar");
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || spike0 !== 4'b0 || res0 !== 32'h0) begin
         n_err++; $display("FAIL async_reset ov=%b ir=%b sp=%b res=%h expected 0 1 0 0", out_valid0, in_ready0, spike0, res0);
      end
      #1 rst = 1'b0;
      send_beat(pk(0, 0, 0, 70), 1'b1, 1'b0);
      wait_out("ar_after");
      n_cmp++;
      if (spike0 !== 4'b0001 || res0 !== pk(0, 0, 0, 6)) begin
         n_err++; $display("FAIL ar_after_dut0 spike=%b res=%h expected 0001 %h", spike0, res0, pk(0, 0, 0, 6));
      end
      n_cmp++;
      if (spike1 !== 4'b0001 || res1 !== 32'h0) begin
         n_err++; $display("FAIL ar_after_dut1 spike=%b res=%h expected 0001 0", spike1, res1);
      end
      consume("ar_after");
   endtask

   initial begin
      test_reset();
      test_single_fire();
      test_threshold();
      test_saturation();
      test_backpressure();
      test_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
